// File: rtl/aes_pkg.sv
// Shared AES definitions: controller states, round count, Rcon endpoints
// and the GF(2^8) doubling/halving helpers used by the round-constant logic.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  localparam int         AES_NR     = 10;
  localparam logic [7:0] RCON_FIRST = 8'h01;
  localparam logic [7:0] RCON_LAST  = 8'h36;

  // Multiply by x in GF(2^8), reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Divide by x in GF(2^8); exact inverse of xtime.
  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
  endfunction

endpackage

// File: rtl/aes_rcon_updown.sv
// Round-constant register. Steps forward (xtime) during expansion and
// backward (inv_xtime) while walking the schedule down; can be forced to
// the first or last AES-128 constant.
import aes_pkg::*;

module aes_rcon_updown (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_first,
  input  logic       load_last,
  input  logic       step_up,
  input  logic       step_down,
  output logic [7:0] rc
);

  // Rcon register; loads take priority over stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rc <= RCON_FIRST;
    else if (load_first) rc <= RCON_FIRST;
    else if (load_last)  rc <= RCON_LAST;
    else if (step_up)    rc <= xtime(rc);
    else if (step_down)  rc <= inv_xtime(rc);
  end

endmodule

// File: rtl/aes_sbox_lut.sv
// AES forward S-box, one byte. Built from the GF(2^8) multiplicative inverse
// (x^254) followed by the FIPS-197 affine transform, so the table never has
// to be typed in by hand.
import aes_pkg::*;

module aes_sbox_lut (
  input  logic [7:0] a,
  output logic [7:0] d
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ s;
      s = xtime(s);
    end
    return p;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] pw;
    logic [7:0] acc;
    pw  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      acc = gf_mul(acc, pw);
    end
    return acc;
  endfunction

  logic [7:0] inv;

  // Inverse then affine map with constant 0x63.
  always_comb begin
    inv = gf_inv(a);
    d   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_inv_key_expand.sv
// AES-128 decryption-side round-key generator. Expands forward to the
// round-10 key, then walks the schedule backwards one round per enable.
// Optional feature macro: AES_INV_KEY_CACHE_EN keeps a copy of the round-10
// key so 'restart' can rewind without re-expanding.
//
// state  | meaning
// IDLE   | no key loaded, outputs hold reset values
// EXPAND | forward schedule running, one round per cycle
// READY  | round key valid, backward stepping allowed
import aes_pkg::*;

module aes_inv_key_expand #(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kld,
  input  logic         enable,
  input  logic         restart,
  input  logic [0:127] key,
  output logic [31:0]  rkey0,
  output logic [31:0]  rkey1,
  output logic [31:0]  rkey2,
  output logic [31:0]  rkey3,
  output logic [3:0]   round,
  output logic         busy,
  output logic         ready
);

  state_t      state_q, state_d;
  logic [31:0] w0_q, w1_q, w2_q, w3_q;
  logic [31:0] w0_d, w1_d, w2_d, w3_d;
  logic [3:0]  round_q, round_d;
  logic [7:0]  rc;
  logic        rc_load_first, rc_load_last, rc_up, rc_down;
  logic        cache_cap;
  logic        restart_req;
  logic [31:0] sbox_in, sbox_out, sw, rcon_w;
  logic [31:0] n0, n1, n2, n3;

  // One shared SubWord: w3 going forward, w3^w2 (the old w3) going back.
  assign sbox_in = (state_q == READY) ? (w3_q ^ w2_q) : w3_q;

  aes_sbox_lut u_sbox3 (.a(sbox_in[31:24]), .d(sbox_out[31:24]));
  aes_sbox_lut u_sbox2 (.a(sbox_in[23:16]), .d(sbox_out[23:16]));
  aes_sbox_lut u_sbox1 (.a(sbox_in[15:8]),  .d(sbox_out[15:8]));
  aes_sbox_lut u_sbox0 (.a(sbox_in[7:0]),   .d(sbox_out[7:0]));

  // RotWord folded into the byte order of the S-box outputs.
  assign sw     = {sbox_out[23:16], sbox_out[15:8], sbox_out[7:0], sbox_out[31:24]};
  assign rcon_w = {rc, 24'h0};

  assign n0 = w0_q ^ sw ^ rcon_w;
  assign n1 = w1_q ^ n0;
  assign n2 = w2_q ^ n1;
  assign n3 = w3_q ^ n2;

  aes_rcon_updown u_rcon (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_first (rc_load_first),
    .load_last  (rc_load_last),
    .step_up    (rc_up),
    .step_down  (rc_down),
    .rc         (rc)
  );

`ifdef AES_INV_KEY_CACHE_EN
  logic [127:0] cache_q;

  // Snapshot of the round-10 key taken on the EXPAND -> READY transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cache_q <= '0;
    else if (cache_cap) cache_q <= {n0, n1, n2, n3};
  end

  assign restart_req = restart;
`else
  logic restart_unused;
  assign restart_unused = restart;
  assign restart_req    = 1'b0;
`endif

  // Next state, next key words and rcon controls; kld > restart > enable.
  always_comb begin
    state_d       = state_q;
    w0_d          = w0_q;
    w1_d          = w1_q;
    w2_d          = w2_q;
    w3_d          = w3_q;
    round_d       = round_q;
    rc_load_first = 1'b0;
    rc_load_last  = 1'b0;
    rc_up         = 1'b0;
    rc_down       = 1'b0;
    cache_cap     = 1'b0;
    if (kld) begin
      state_d       = EXPAND;
      w0_d          = key[0:31];
      w1_d          = key[32:63];
      w2_d          = key[64:95];
      w3_d          = key[96:127];
      round_d       = 4'd0;
      rc_load_first = 1'b1;
    end else begin
      case (state_q)
        EXPAND: begin
          w0_d    = n0;
          w1_d    = n1;
          w2_d    = n2;
          w3_d    = n3;
          round_d = round_q + 4'd1;
          if (round_q == 4'(NR - 1)) begin
            state_d      = READY;
            rc_load_last = 1'b1;
            cache_cap    = 1'b1;
          end else begin
            rc_up = 1'b1;
          end
        end
        READY: begin
          if (restart_req) begin
`ifdef AES_INV_KEY_CACHE_EN
            w0_d = cache_q[127:96];
            w1_d = cache_q[95:64];
            w2_d = cache_q[63:32];
            w3_d = cache_q[31:0];
`endif
            round_d      = 4'(NR);
            rc_load_last = 1'b1;
          end else if (enable && (round_q != 4'd0)) begin
            w3_d    = w3_q ^ w2_q;
            w2_d    = w2_q ^ w1_q;
            w1_d    = w1_q ^ w0_q;
            w0_d    = n0;
            round_d = round_q - 4'd1;
            rc_down = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, key words and round index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      w3_q    <= w3_d;
      round_q <= round_d;
    end
  end

  assign rkey0 = w0_q;
  assign rkey1 = w1_q;
  assign rkey2 = w2_q;
  assign rkey3 = w3_q;
  assign round = round_q;
  assign busy  = (state_q == EXPAND);
  assign ready = (state_q == READY);

endmodule

// File: doc/aes_inv_key_expand.md
# aes_inv_key_expand

Decryption-side AES-128 round-key generator. It accepts the cipher key and runs the forward schedule to round 10 in 10 cycles. It then steps the schedule backwards one round per `enable`, delivering round keys 10 → 0 in the order the inverse cipher consumes them. It sits beside `aes_key_expand` and feeds the inverse-cipher datapath without a 44-word key RAM.

## Interface
Parameters:
- `NR`, 10, number of rounds; AES-128 only.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `kld`  in  1  load `key` and start forward expansion.
- `enable`  in  1  step one round backwards; honoured only while `ready`.
- `restart`  in  1  return to the round-10 key; effective only with `AES_INV_KEY_CACHE_EN`.
- `key`  in  [0:127]  cipher key; `key[0:31]` is w0.
- `rkey0..rkey3`  out  32 each  current round key words w0..w3.
- `round`  out  4  index of the round key currently on `rkey*`.
- `busy`  out  1  forward expansion in progress.
- `ready`  out  1  round key valid; backward stepping allowed.

## Operation
- FSM states are IDLE, EXPAND and READY.
  - IDLE → EXPAND on `kld`.
  - EXPAND → READY when the count reaches 10.
  - READY → EXPAND on `kld`.
- SubWord/RotWord: `sw(x) = {S(x[23:16]), S(x[15:8]), S(x[7:0]), S(x[31:24])}`. Rcon word is `{rc, 24'h0}`.
- Forward step (EXPAND):
  - `n0 = w0^sw(w3)^rcon`, `n1 = w1^n0`, `n2 = w2^n1`, `n3 = w3^n2`.
  - `rc` starts at 0x01; then `rc <= xtime(rc)`, with 0x1b reduction.
- Backward step (READY, `enable`, `round != 0`):
  - `w3' = w3^w2`, `w2' = w2^w1`, `w1' = w1^w0`, `w0' = w0^sw(w3^w2)^rcon`.
  - Then `rc <= inv_xtime(rc)`: if `rc[0]` then `(rc^0x1b)>>1|0x80`, else `rc>>1`.
- On entry to READY, `rc` is forced to 0x36.
- One shared set of 4 S-boxes. Its input is muxed: `w3` in EXPAND, `w3^w2` in READY.
- Priority: `kld` > `restart` > `enable`.
- `enable` with `round == 0`, or outside READY, is ignored and state is held.
- `kld` during EXPAND or READY aborts the current sequence and reloads.

## Timing
- Reset values: `rkey*` = 0, `round` = 0, `busy` = 0, `ready` = 0, `rc` = 0x01, state IDLE.
- Edge E0 with `kld`:
  - After E0: `rkey*` = key, `round` = 0, `busy` = 1.
  - Edges E1..E10 perform forward steps, with `round` incrementing.
  - After E10: `round` = 10, `rkey*` = round-10 key, `busy` = 0, `ready` = 1.
  - Latency from the `kld` edge to `ready` is 10 cycles.
- Backward step: the new key and `round-1` appear the cycle after the `enable` edge. Back-to-back `enable` gives one key per cycle.
- `ready` stays 1 through all backward steps. It drops only on `kld` (→ `busy`) or reset.
- `rst_n` low mid-EXPAND or mid-READY clears everything asynchronously. Outputs are valid again only after a fresh `kld`.

## Configuration
- `AES_INV_KEY_CACHE_EN` defined:
  - A 128-bit register captures the round-10 key on EXPAND → READY.
  - `restart` in READY reloads it next cycle: `round` = 10, `rc` = 0x36.
  - This allows repeated block decryptions without re-expansion.
- Undefined: no cache register; `restart` is ignored. A new `kld` (10 cycles) is required.

## Structure
- Shared package `aes_pkg`:
  - state enum `{IDLE, EXPAND, READY}`
  - `AES_NR = 10`
  - `RCON_FIRST = 8'h01`, `RCON_LAST = 8'h36`
  - functions `xtime` and `inv_xtime`
- Reuses `aes_sbox_lut` ×4.
- One natural sub-module, `aes_rcon_updown`: the `rc` register with load-01, load-36, step-up and step-down controls.

## Test plan
- Reset then idle: all outputs 0; `enable` toggling leaves `round` = 0, `ready` = 0.
- `kld` key `2b7e151628aed2a6abf7158809cf4f3c`: `busy` for 10 cycles, then `ready`, `round` = 10, `rkey*` = `d014f9a8c9ee2589e13f0cc8b6630ca6`.
- Then 10 back-to-back `enable`:
  - round 9 = `ac7766f319fadc2128d12941575c006e`
  - round 1 = `a0fafe1788542cb123a339392a6c7605`
  - round 0 = original key
  - an 11th `enable` holds round 0.
- `kld` asserted at forward cycle 5 with a new key: expansion restarts; `ready` arrives 10 cycles after the second `kld`, with the correct round-10 key.
- `kld` and `enable` together in READY: load wins, `round` = 0, `busy` = 1.
- `AES_INV_KEY_CACHE_EN`: after stepping to round 3, `restart` gives round 10 = `d014…0ca6` next cycle, and `enable` then yields the round-9 key. Without the macro, `restart` leaves round 3 unchanged.
